ifetch_ctrl: RTL and testbench
==============================

# ifetch_ctrl

Instruction-fetch controller between the `riscv` core and its two instruction sources: the on-chip boot ROM (PC bit 31 = 0) and the external instruction port (PC bit 31 = 1). It accepts one fetch request at a time from the core and drives the selected source. On the external port it runs the rising-edge valid handshake. It stalls the core until the instruction is ready and returns a NOP with a sticky fault code on timeout or a misaligned PC. It replaces the free-running ROM enable and combinational source mux in `riscv_top`.

## Interface
- `TIMEOUT`, 255: maximum cycles spent waiting for an external valid edge; legal range 1..65535.
- `NOP`, 32'h0000_0013: instruction returned on any fault.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; all state is cleared while low.
- `core_req`  in  1  core requests the instruction at `core_pc`; held high until `core_instr_vld`.
- `core_pc`  in  32  fetch address; sampled only when a request is accepted.
- `core_instr`  out  32  fetched instruction; meaningful only while `core_instr_vld` is high.
- `core_instr_vld`  out  1  one-cycle response pulse.
- `core_stall`  out  1  fetch in progress; drives the core's suspend.
- `rom_en`  out  1  boot ROM read enable.
- `rom_addr`  out  31  ROM address, equal to the latched pc[30:0].
- `rom_instr`  in  32  ROM data; registered, valid the cycle after `rom_en`.
- `ext_req`  out  1  external fetch request.
- `ext_addr`  out  32  latched pc.
- `ext_instr`  in  32  external instruction word.
- `ext_valid`  in  1  external data valid; level signal, only its rising edge counts.
- `fault`  out  1  sticky; cleared only by reset.
- `fault_code`  out  2  01 = timeout, 10 = misaligned; first fault wins.

## Operation
- **States:** IDLE, ROM_RD, ROM_CAP, EXT_WAIT, RESP.
- **IDLE**, when `core_req` is high, latch `pc_q <= core_pc` and then branch:
  - `core_pc[1:0] != 0`: `instr_q <= NOP`, record misaligned fault, go to RESP.
  - `core_pc[31] = 0`: go to ROM_RD.
  - otherwise: clear the timer and go to EXT_WAIT.
- **ROM_RD:** `rom_en = 1`, `rom_addr = pc_q[30:0]`; go to ROM_CAP.
- **ROM_CAP:** `instr_q <= rom_instr`; go to RESP.
- **EXT_WAIT:** `ext_req = 1`, `ext_addr = pc_q`.
  - Rising edge of `ext_valid` (`ext_valid & ~ext_valid_q`): `instr_q <= ext_instr`, go to RESP.
  - Otherwise, when timer = `TIMEOUT - 1`: `instr_q <= NOP`, record timeout fault, go to RESP.
  - The timer increments by 1 per cycle in this state and never wraps.
- **RESP:** `core_instr_vld = 1`; go to IDLE. A new request can be accepted in the following IDLE cycle.
- `ext_valid_q` is registered every cycle in every state. If `ext_valid` is already high on entry to EXT_WAIT, it must fall and rise again before data is accepted.
- `core_stall = (state != IDLE && state != RESP) | (state == IDLE & core_req)`.
- Once accepted, a fetch always completes. Dropping `core_req` or changing `core_pc` mid-fetch has no effect.
- Fault recording: the first fault sets `fault` and `fault_code`; later faults still return NOP but do not change `fault_code`.
- An external valid edge and the timeout in the same cycle: the data wins and no fault is recorded.
- `ext_valid` edges outside EXT_WAIT are ignored.

## Timing
- Reset values: state IDLE; every output 0, including `core_instr`, `fault`, `fault_code`, `rom_addr` and `ext_addr`; `ext_valid_q` 0.
- Assertion of `reset` mid-fetch aborts immediately: `rom_en`/`ext_req` drop asynchronously and no `core_instr_vld` is issued.
- Latency from the accepting edge to `core_instr_vld` high:
  - ROM fetch: 3 cycles.
  - Misaligned PC: 1 cycle.
  - External fetch: k+1 cycles for an edge k cycles after entry; `TIMEOUT`+1 cycles on timeout.
- Back-to-back ROM throughput: one instruction every 4 cycles.
- `core_instr` is registered. It holds its value after the response until the next capture.

## Structure
- Package `ifetch_pkg`: state enum `ifetch_state_t`, `NOP_INSTR`, fault code constants `FLT_NONE`/`FLT_TIMEOUT`/`FLT_MISALIGN`.
- One sub-module, `ifetch_timer`: saturating counter parameterised by `TIMEOUT`, with clear/enable inputs and an `expire` output.

## Test plan
- ROM fetch: `core_pc = 0x0000_0040`, `rom_instr = 0x0000_0093` → `rom_en` high for exactly 1 cycle with `rom_addr = 0x40`; `core_instr_vld` 3 cycles after acceptance with `core_instr = 0x0000_0093`; `core_stall` high throughout.
- External fetch: `core_pc = 0x8000_0100`, `ext_valid` rises 5 cycles later with `ext_instr = 0x00A0_0513` → `ext_req` high for 5 cycles, then `core_instr = 0x00A0_0513`, `fault = 0`.
- Stale valid: `ext_valid` held high before the request → no capture; data is accepted only after `ext_valid` goes 0→1.
- Timeout with `TIMEOUT = 8` and no edge → `core_instr = 0x0000_0013` after 9 cycles, `fault = 1`, `fault_code = 01`.
  - A following misaligned request (`core_pc = 0x2`) returns NOP in 1 cycle and `fault_code` stays 01.
- Reset low during EXT_WAIT → outputs go to 0 immediately, no `core_instr_vld`; a new ROM fetch after release completes normally.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package ifetch_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TMR_W = 16;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_TIMEOUT  = 2'b01;
  localparam logic [1:0] FLT_MISALIGN = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROM_RD,
    ST_ROM_CAP,
    ST_EXT_WAIT,
    ST_RESP
  } ifetch_state_t;

endpackage

// File: rtl/ifetch_timer.sv
// Saturating wait counter; expire flags the last allowed cycle of an external wait.
module ifetch_timer
  import ifetch_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire_c
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] r_cnt;

  // Holds at LAST so the count never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + TMR_W'(1);
    end
  end

  assign o_expire_c = (r_cnt == LAST);

endmodule

// File: rtl/ifetch_ctrl.sv
// Single-outstanding fetch controller steering the core between boot ROM and the
// external instruction port, with timeout/misalignment faults returning a NOP.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int unsigned     TIMEOUT = 255,
  parameter logic [XLEN-1:0] NOP     = NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            core_req,
  input  logic [XLEN-1:0] core_pc,
  output logic [XLEN-1:0] core_instr,
  output logic            core_instr_vld,
  output logic            core_stall,
  output logic            rom_en,
  output logic [30:0]     rom_addr,
  input  logic [XLEN-1:0] rom_instr,
  output logic            ext_req,
  output logic [XLEN-1:0] ext_addr,
  input  logic [XLEN-1:0] ext_instr,
  input  logic            ext_valid,
  output logic            fault,
  output logic [1:0]      fault_code
);

  ifetch_state_t   r_state;
  ifetch_state_t   w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic            r_vld;
  logic            r_rom_en;
  logic            r_ext_req;
  logic            r_ext_valid_q;
  logic            r_fault;
  logic [1:0]      r_fault_code;

  logic            w_pc_ld;
  logic            w_instr_ld;
  logic [XLEN-1:0] w_instr_d;
  logic            w_flt_evt;
  logic [1:0]      w_flt_d;
  logic            w_tmr_clr;
  logic            w_tmr_en;
  logic            w_expire;
  logic            w_ext_edge;

  assign w_ext_edge = ext_valid & ~r_ext_valid_q;

  ifetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_tmr_clr),
    .i_en       (w_tmr_en),
    .o_expire_c (w_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_ld     = 1'b0;
    w_instr_ld  = 1'b0;
    w_instr_d   = r_instr;
    w_flt_evt   = 1'b0;
    w_flt_d     = FLT_NONE;
    w_tmr_clr   = 1'b0;
    w_tmr_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (core_req) begin
          w_pc_ld = 1'b1;
          if (core_pc[1:0] != 2'b00) begin
            w_instr_ld  = 1'b1;
            w_instr_d   = NOP;
            w_flt_evt   = 1'b1;
            w_flt_d     = FLT_MISALIGN;
            w_state_nxt = ST_RESP;
          end else if (!core_pc[31]) begin
            w_state_nxt = ST_ROM_RD;
          end else begin
            w_tmr_clr   = 1'b1;
            w_state_nxt = ST_EXT_WAIT;
          end
        end
      end
      ST_ROM_RD: w_state_nxt = ST_ROM_CAP;
      ST_ROM_CAP: begin
        w_instr_ld  = 1'b1;
        w_instr_d   = rom_instr;
        w_state_nxt = ST_RESP;
      end
      ST_EXT_WAIT: begin
        w_tmr_en = 1'b1;
        // A data edge coinciding with expiry takes priority over the timeout.
        if (w_ext_edge) begin
          w_instr_ld  = 1'b1;
          w_instr_d   = ext_instr;
          w_state_nxt = ST_RESP;
        end else if (w_expire) begin
          w_instr_ld  = 1'b1;
          w_instr_d   = NOP;
          w_flt_evt   = 1'b1;
          w_flt_d     = FLT_TIMEOUT;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc          <= '0;
      r_instr       <= '0;
      r_vld         <= 1'b0;
      r_rom_en      <= 1'b0;
      r_ext_req     <= 1'b0;
      r_ext_valid_q <= 1'b0;
    end else begin
      if (w_pc_ld)    r_pc    <= core_pc;
      if (w_instr_ld) r_instr <= w_instr_d;
      r_vld         <= (w_state_nxt == ST_RESP);
      r_rom_en      <= (w_state_nxt == ST_ROM_RD);
      r_ext_req     <= (w_state_nxt == ST_EXT_WAIT);
      r_ext_valid_q <= ext_valid;
    end
  end

  // First fault since reset wins; later faults leave the code untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fault      <= 1'b0;
      r_fault_code <= FLT_NONE;
    end else if (w_flt_evt && !r_fault) begin
      r_fault      <= 1'b1;
      r_fault_code <= w_flt_d;
    end
  end

  assign core_instr     = r_instr;
  assign core_instr_vld = r_vld;
  assign rom_en         = r_rom_en;
  assign rom_addr       = r_pc[30:0];
  assign ext_req        = r_ext_req;
  assign ext_addr       = r_pc;
  assign fault          = r_fault;
  assign fault_code     = r_fault_code;
  assign core_stall     = ((r_state != ST_IDLE) && (r_state != ST_RESP)) ||
                          ((r_state == ST_IDLE) && core_req);

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed and randomized fetches against a latency/result model derived from the
// fetch rules (source by pc, edge timing, timeout window, sticky first fault).
module tb_ifetch_ctrl;
  import ifetch_pkg::*;

  localparam int unsigned TO = 8;

  logic        clk;
  logic        reset;
  logic        core_req;
  logic [31:0] core_pc;
  logic [31:0] core_instr;
  logic        core_instr_vld;
  logic        core_stall;
  logic        rom_en;
  logic [30:0] rom_addr;
  logic [31:0] rom_instr;
  logic        ext_req;
  logic [31:0] ext_addr;
  logic [31:0] ext_instr;
  logic        ext_valid;
  logic        fault;
  logic [1:0]  fault_code;

  int          n_pass;
  int          n_chk;
  bit          m_fault;
  logic [1:0]  m_code;

  ifetch_ctrl #(.TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .core_req       (core_req),
    .core_pc        (core_pc),
    .core_instr     (core_instr),
    .core_instr_vld (core_instr_vld),
    .core_stall     (core_stall),
    .rom_en         (rom_en),
    .rom_addr       (rom_addr),
    .rom_instr      (rom_instr),
    .ext_req        (ext_req),
    .ext_addr       (ext_addr),
    .ext_instr      (ext_instr),
    .ext_valid      (ext_valid),
    .fault          (fault),
    .fault_code     (fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [30:0] a);
    if (a == 31'h40) return 32'h0000_0093;
    return {a[15:0], a[30:15]} ^ 32'h5A5A_0003;
  endfunction

  // Registered boot ROM: data appears the cycle after the enable.
  always @(posedge clk) begin
    if (rom_en) rom_instr <= rom_word(rom_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_instr"},    core_instr, 32'h0);
    chk({tag, "_vld"},      32'(core_instr_vld), 32'h0);
    chk({tag, "_stall"},    32'(core_stall), 32'h0);
    chk({tag, "_rom_en"},   32'(rom_en), 32'h0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 32'h0);
    chk({tag, "_ext_req"},  32'(ext_req), 32'h0);
    chk({tag, "_ext_addr"}, ext_addr, 32'h0);
    chk({tag, "_fault"},    32'(fault), 32'h0);
    chk({tag, "_code"},     32'(fault_code), 32'h0);
  endtask

  // Issue one fetch at the current negedge; k = cycle of the external edge after entry.
  task automatic fetch(input logic [31:0] pc, input int k, input bit stale,
                       input logic [31:0] edata);
    bit          mis, rom, hit, done, stall_ok, addr_ok;
    int          exp_lat, got, rom_cnt, ext_cnt, exp_ext_cnt;
    logic [31:0] exp_instr;
    logic [1:0]  evt;
    mis = (pc[1:0] != 2'b00);
    rom = !mis && !pc[31];
    hit = !mis && !rom && (k <= int'(TO));
    evt = FLT_NONE;
    if (mis) begin
      exp_lat = 1; exp_instr = NOP_INSTR; evt = FLT_MISALIGN;
    end else if (rom) begin
      exp_lat = 3; exp_instr = rom_word(pc[30:0]);
    end else if (hit) begin
      exp_lat = k + 1; exp_instr = edata;
    end else begin
      exp_lat = int'(TO) + 1; exp_instr = NOP_INSTR; evt = FLT_TIMEOUT;
    end
    if ((evt != FLT_NONE) && !m_fault) begin
      m_fault = 1'b1;
      m_code  = evt;
    end
    exp_ext_cnt = (!mis && !rom) ? exp_lat - 1 : 0;

    core_req  = 1'b1;
    core_pc   = pc;
    ext_instr = edata;
    ext_valid = (mis || rom) ? 1'($urandom_range(0, 1)) : stale;
    #1;
    stall_ok = (core_stall === 1'b1);
    done = 1'b0; got = -1; rom_cnt = 0; ext_cnt = 0; addr_ok = 1'b1;
    for (int c = 1; (c <= int'(TO) + 4) && !done; c++) begin
      @(negedge clk);
      if (c == 1) begin
        core_pc = $urandom;
        if ($urandom_range(0, 3) == 0) core_req = 1'b0;
      end
      if (rom_en) begin
        rom_cnt++;
        if (rom_addr !== pc[30:0]) addr_ok = 1'b0;
      end
      if (ext_req) begin
        ext_cnt++;
        if (ext_addr !== pc) addr_ok = 1'b0;
      end
      if (core_instr_vld) begin
        done = 1'b1;
        got  = c;
      end else if (core_stall !== 1'b1) begin
        stall_ok = 1'b0;
      end
      if (mis || rom)  ext_valid = 1'($urandom_range(0, 1));
      else if (stale)  ext_valid = (c != k - 1);
      else             ext_valid = (c >= k);
    end
    chk("latency",        32'(got), 32'(exp_lat));
    chk("instr",          core_instr, exp_instr);
    chk("fault",          32'(fault), 32'(m_fault));
    chk("fault_code",     32'(fault_code), 32'(m_code));
    chk("stall_in_resp",  32'(core_stall), 32'h0);
    chk("stall_busy",     32'(stall_ok), 32'h1);
    chk("rom_en_cycles",  32'(rom_cnt), rom ? 32'h1 : 32'h0);
    chk("ext_req_cycles", 32'(ext_cnt), 32'(exp_ext_cnt));
    chk("addr_out",       32'(addr_ok), 32'h1);
    core_req = 1'b0;
    @(negedge clk);
    chk("vld_one_cycle",  32'(core_instr_vld), 32'h0);
    chk("instr_hold",     core_instr, exp_instr);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] pc;
    logic [1:0]  lb;
    int          kk;
    int          sel;
    bit          st;
    n_pass = 0; n_chk = 0;
    m_fault = 1'b0; m_code = FLT_NONE;
    reset = 1'b0; core_req = 1'b0; core_pc = '0;
    ext_instr = '0; ext_valid = 1'b0;
    #12;
    chk_zero("reset_val");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    fetch(32'h0000_0040, 0, 1'b0, 32'h0);
    fetch(32'h0000_0044, 0, 1'b0, 32'h0);
    fetch(32'h8000_0100, 5, 1'b0, 32'h00A0_0513);
    fetch(32'h8000_0104, 4, 1'b1, 32'hDEAD_BEE3);
    fetch(32'h8000_0108, int'(TO), 1'b0, 32'h0123_4567);
    fetch(32'h8000_010C, int'(TO) + 3, 1'b0, 32'hFFFF_FFFF);
    fetch(32'h0000_0002, 0, 1'b0, 32'h0);
    fetch(32'h8000_0110, int'(TO) + 2, 1'b1, 32'h5555_AAAA);

    // Reset mid external wait must abort the fetch at once.
    core_req  = 1'b1;
    core_pc   = 32'h8000_0200;
    ext_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_ext_req", 32'(ext_req), 32'h1);
    reset    = 1'b0;
    core_req = 1'b0;
    #1;
    chk_zero("mid_rst");
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_vld", 32'(core_instr_vld), 32'h0);
    end
    reset   = 1'b1;
    m_fault = 1'b0;
    m_code  = FLT_NONE;
    @(negedge clk);
    fetch(32'h0000_0080, 0, 1'b0, 32'h0);

    for (int i = 0; i < 60; i++) begin
      r   = $urandom;
      sel = $urandom_range(0, 5);
      kk  = $urandom_range(1, TO + 3);
      st  = 1'($urandom_range(0, 1));
      lb  = 2'($urandom_range(1, 3));
      if (sel < 2)      pc = {1'b0, r[30:2], 2'b00};
      else if (sel < 5) pc = {1'b1, r[30:2], 2'b00};
      else              pc = {r[31:2], lb};
      if (st && kk < 2) kk = 2;
      fetch(pc, kk, st, $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
